// File: rtl/fma_path_select_pipe_if.sv
// fma_path_select_pipe_if
//   Bundles the operand-side and result-side valid/ready handshakes of the
//   FMA near/far path selector.
//   Operand side : in_valid, in_ready, a_exp, b_exp, c_exp, d_exp, op_sel
//   Result side  : out_valid, out_ready, path_sel, swap, exp_diff, shift_amt, max_exp
//   modport master : the environment (drives operands, consumes results)
//   modport slave  : the selector pipeline itself
interface fma_path_select_pipe_if #(
  parameter int unsigned EXP_W   = 8,
  parameter int unsigned SHIFT_W = 5
) ();

  // Operand side
  logic               in_valid;
  logic               in_ready;
  logic [EXP_W-1:0]   a_exp;
  logic [EXP_W-1:0]   b_exp;
  logic [EXP_W-1:0]   c_exp;
  logic [EXP_W-1:0]   d_exp;
  logic [7:0]         op_sel;

  // Result side
  logic               out_valid;
  logic               out_ready;
  logic               path_sel;
  logic               swap;
  logic [EXP_W+1:0]   exp_diff;
  logic [SHIFT_W-1:0] shift_amt;
  logic [EXP_W+1:0]   max_exp;

  modport master (
    output in_valid,
    output a_exp,
    output b_exp,
    output c_exp,
    output d_exp,
    output op_sel,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  path_sel,
    input  swap,
    input  exp_diff,
    input  shift_amt,
    input  max_exp
  );

  modport slave (
    input  in_valid,
    input  a_exp,
    input  b_exp,
    input  c_exp,
    input  d_exp,
    input  op_sel,
    input  out_ready,
    output in_ready,
    output out_valid,
    output path_sel,
    output swap,
    output exp_diff,
    output shift_amt,
    output max_exp
  );

endinterface

// File: rtl/fma_path_select_pipe.sv
// fma_path_select_pipe
//   Two-stage near/far path selector for a*b +/- c*d.
//   Stage 1 forms the bias-corrected product exponents ab = a+b-BIAS and
//   cd = c+d-BIAS (signed, EXP_W+2 bits, cannot wrap) plus a multiply-only flag.
//   Stage 2 forms |ab-cd|, the swap flag, the saturated shift amount, the larger
//   product exponent and the near/far decision, and holds them for the consumer.
//
//   Ports
//     clk       : clock, rising edge
//     rst       : synchronous active-high reset
//     bus       : fma_path_select_pipe_if.slave (operand and result handshakes)
//     stats_clr : zero the path counters (PATH_SEL_STATS_EN only)
//     near_cnt  : results delivered on the near path (PATH_SEL_STATS_EN only)
//     far_cnt   : results delivered on the far path (PATH_SEL_STATS_EN only)
//
//   Build option
//     PATH_SEL_STATS_EN : when defined, adds saturating per-path delivery
//                         counters with a clear input. Datapath is unchanged.
//
//   Flow control is a single global advance: both stages move together when the
//   output register is empty or being consumed, otherwise both hold. Bubbles
//   travel through as empty slots. Assumes SHIFT_W < EXP_W+2.
module fma_path_select_pipe #(
  parameter int unsigned EXP_W       = 8,
  parameter int unsigned BIAS        = 127,
  parameter int unsigned NEAR_THRESH = 2,
  parameter int unsigned SHIFT_W     = 5,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef PATH_SEL_STATS_EN
  input  logic             stats_clr,
  output logic [CNT_W-1:0] near_cnt,
  output logic [CNT_W-1:0] far_cnt,
`endif
  fma_path_select_pipe_if.slave bus
);

  localparam int unsigned DW = EXP_W + 2;

  typedef logic signed [DW-1:0] sexp_t;

  localparam sexp_t          BiasS    = sexp_t'(BIAS);
  localparam logic [DW-1:0]  NearThr  = DW'(NEAR_THRESH);
  localparam logic [DW-1:0]  ShiftMax = DW'((64'd1 << SHIFT_W) - 64'd1);

  // ---------------------------------------------------------------------------
  // Global advance
  // ---------------------------------------------------------------------------
  logic adv;
  logic out_valid_q, out_valid_d;

  assign adv          = bus.out_ready | ~out_valid_q;
  assign bus.in_ready = adv;

  // ---------------------------------------------------------------------------
  // Stage 1: product exponents
  // ---------------------------------------------------------------------------
  logic  s1_valid_q, s1_valid_d;
  sexp_t ab_q, ab_d;
  sexp_t cd_q, cd_d;
  logic  mul_only_q, mul_only_d;
  sexp_t ab_new, cd_new;

  // Zero-extend the biased exponents by two bits, then remove the bias once per
  // product. Range is [-BIAS, 2*(2^EXP_W-1)-BIAS], which fits in EXP_W+2 signed.
  always_comb begin
    ab_new = $signed({2'b00, bus.a_exp}) + $signed({2'b00, bus.b_exp}) - BiasS;
    cd_new = $signed({2'b00, bus.c_exp}) + $signed({2'b00, bus.d_exp}) - BiasS;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    ab_d       = ab_q;
    cd_d       = cd_q;
    mul_only_d = mul_only_q;
    if (adv) begin
      s1_valid_d = bus.in_valid;
      // Data only loads for a real operand set; a bubble leaves the old payload.
      if (bus.in_valid) begin
        ab_d       = ab_new;
        cd_d       = cd_new;
        mul_only_d = (bus.op_sel == 8'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      ab_q       <= '0;
      cd_q       <= '0;
      mul_only_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      ab_q       <= ab_d;
      cd_q       <= cd_d;
      mul_only_q <= mul_only_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: difference, swap, shift, path decision
  // ---------------------------------------------------------------------------
  sexp_t              diff_s;
  logic               swap_c;
  logic [DW-1:0]      exp_diff_c;
  logic [SHIFT_W-1:0] shift_c;
  logic               path_c;
  sexp_t              max_c;

  // ab and cd each span less than half the signed range, so ab-cd cannot overflow.
  always_comb begin
    diff_s     = ab_q - cd_q;
    swap_c     = diff_s[DW-1];
    exp_diff_c = swap_c ? $unsigned(-diff_s) : $unsigned(diff_s);
    if (exp_diff_c > ShiftMax) begin
      shift_c = '1;
    end else begin
      shift_c = exp_diff_c[SHIFT_W-1:0];
    end
    // A multiply-only op has no addend to align, so it always takes the near path.
    path_c = (exp_diff_c <= NearThr) | mul_only_q;
    max_c  = swap_c ? cd_q : ab_q;
  end

  logic               path_q, path_d;
  logic               swap_q, swap_d;
  logic [DW-1:0]      exp_diff_q, exp_diff_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  sexp_t              max_q, max_d;

  always_comb begin
    out_valid_d = out_valid_q;
    path_d      = path_q;
    swap_d      = swap_q;
    exp_diff_d  = exp_diff_q;
    shift_d     = shift_q;
    max_d       = max_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        path_d     = path_c;
        swap_d     = swap_c;
        exp_diff_d = exp_diff_c;
        shift_d    = shift_c;
        max_d      = max_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      path_q      <= 1'b0;
      swap_q      <= 1'b0;
      exp_diff_q  <= '0;
      shift_q     <= '0;
      max_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      path_q      <= path_d;
      swap_q      <= swap_d;
      exp_diff_q  <= exp_diff_d;
      shift_q     <= shift_d;
      max_q       <= max_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.path_sel  = path_q;
  assign bus.swap      = swap_q;
  assign bus.exp_diff  = exp_diff_q;
  assign bus.shift_amt = shift_q;
  assign bus.max_exp   = $unsigned(max_q);

  // ---------------------------------------------------------------------------
  // Optional per-path delivery counters
  // ---------------------------------------------------------------------------
`ifdef PATH_SEL_STATS_EN
  logic             out_hs;
  logic [CNT_W-1:0] near_cnt_q, near_cnt_d;
  logic [CNT_W-1:0] far_cnt_q, far_cnt_d;

  assign out_hs = out_valid_q & bus.out_ready;

  always_comb begin
    near_cnt_d = near_cnt_q;
    far_cnt_d  = far_cnt_q;
    if (stats_clr) begin
      near_cnt_d = '0;
      far_cnt_d  = '0;
    end else if (out_hs) begin
      if (path_q) begin
        if (near_cnt_q != '1) near_cnt_d = near_cnt_q + 1'b1;
      end else begin
        if (far_cnt_q != '1) far_cnt_d = far_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      near_cnt_q <= '0;
      far_cnt_q  <= '0;
    end else begin
      near_cnt_q <= near_cnt_d;
      far_cnt_q  <= far_cnt_d;
    end
  end

  assign near_cnt = near_cnt_q;
  assign far_cnt  = far_cnt_q;
`else
  // Counter width is meaningless without the counters; keep it referenced.
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule
